// File: rtl/tx_irq_pkg.sv
// tx_irq_pkg: shared types and helpers for the multi-ring
// tx interrupt coalescer.
package tx_irq_pkg;

    localparam int unsigned NCH_DEF = 2;
    localparam int unsigned PW_DEF  = 64;
    localparam int unsigned TW_DEF  = 16;
    localparam int unsigned CW_DEF  = 8;
    localparam int unsigned GAP_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } irq_state_e;

    // Low bit of channel ch inside a packed bus of w-wide fields.
    function automatic int unsigned ch_lsb(
        input int unsigned ch,
        input int unsigned w
    );
        return ch * w;
    endfunction

    // High bit of channel ch inside a packed bus of w-wide fields.
    function automatic int unsigned ch_msb(
        input int unsigned ch,
        input int unsigned w
    );
        return ch * w + w - 1;
    endfunction

endpackage

// File: rtl/tx_irq_coal_ch.sv
// tx_irq_coal_ch: one tx ring's pointer tracking, producer
// handshake and event/timeout coalescing.
module tx_irq_coal_ch
    import tx_irq_pkg::*;
#(
    parameter int unsigned PW = PW_DEF,
    parameter int unsigned TW = TW_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          data_rdy,
    output logic          data_rdy_ack,
    input  logic [PW-1:0] hw_ptr,
    input  logic          sw_ptr_update,
    input  logic [PW-1:0] sw_ptr,
    input  logic [CW-1:0] coal_count,
    input  logic [TW-1:0] coal_timeout,
    input  logic          clr_fire,
    output logic          fire
);

    logic          ack_q;
    logic          ack_d;
    logic [PW-1:0] hw_q;
    logic [PW-1:0] hw_d;
    logic [PW-1:0] sw_q;
    logic [PW-1:0] sw_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [TW-1:0] tmr_q;
    logic [TW-1:0] tmr_d;
    logic          armed_q;
    logic          armed_d;
    logic          capture;
    logic          pending;
    logic          tmr_on;

    assign data_rdy_ack = ack_q;

    // Next-state: a sw update (or a served interrupt) clears the
    // counters before a same-cycle capture adds its event.
    always_comb begin
        capture = data_rdy & ~ack_q;
        pending = (hw_q != sw_q);
        tmr_on  = (coal_timeout != '0);
        fire    = armed_q & pending &
                  ((cnt_q >= coal_count) |
                   (tmr_on & (tmr_q == coal_timeout)));

        ack_d = capture;
        hw_d  = capture ? hw_ptr : hw_q;
        sw_d  = sw_ptr_update ? sw_ptr : sw_q;

        armed_d = armed_q;
        if (clr_fire)
            armed_d = 1'b0;
        if (sw_ptr_update)
            armed_d = 1'b1;

        cnt_d = cnt_q;
        if (clr_fire | sw_ptr_update)
            cnt_d = '0;
        if (capture && (cnt_d != '1))
            cnt_d = cnt_d + CW'(1);

        tmr_d = tmr_q;
        if (!pending || clr_fire || sw_ptr_update)
            tmr_d = '0;
        else if (armed_q && tmr_on && (tmr_q < coal_timeout))
            tmr_d = tmr_q + TW'(1);
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q   <= 1'b0;
            hw_q    <= '0;
            sw_q    <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            armed_q <= 1'b1;
        end else begin
            ack_q   <= ack_d;
            hw_q    <= hw_d;
            sw_q    <= sw_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/tx_irq_coal.sv
// tx_irq_coal: NCH tx rings with per-ring coalescing merged
// into one interrupt request/acknowledge handshake.
module tx_irq_coal
    import tx_irq_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEF,
    parameter int unsigned PW  = PW_DEF,
    parameter int unsigned TW  = TW_DEF,
    parameter int unsigned CW  = CW_DEF,
    parameter int unsigned GAP = GAP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    data_rdy,
    output logic [NCH-1:0]    data_rdy_ack,
    input  logic [NCH*PW-1:0] hw_ptr,
    input  logic [NCH-1:0]    sw_ptr_update,
    input  logic [NCH*PW-1:0] sw_ptr,
    input  logic              irq_en,
    input  logic [CW-1:0]     coal_count,
    input  logic [TW-1:0]     coal_timeout,
    output logic              send_irq,
    input  logic              irq_ack,
    output logic [NCH-1:0]    irq_vec
);

    localparam int unsigned GW = $clog2(GAP + 1);

    irq_state_e     state_q;
    logic           send_q;
    logic [NCH-1:0] vec_q;
    logic [GW-1:0]  gap_q;
    logic [NCH-1:0] fire;
    logic [NCH-1:0] clr;
    logic           take;

    assign send_irq = send_q;
    assign irq_vec  = vec_q;

    // A request is launched only from IDLE; the firing channels
    // are disarmed in the same cycle they are latched into irq_vec.
    always_comb begin
        take = (state_q == ST_IDLE) & irq_en & (|fire);
        clr  = take ? fire : '0;
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        tx_irq_coal_ch #(
            .PW(PW),
            .TW(TW),
            .CW(CW)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .data_rdy     (data_rdy[i]),
            .data_rdy_ack (data_rdy_ack[i]),
            .hw_ptr       (hw_ptr[ch_lsb(i, PW) +: PW]),
            .sw_ptr_update(sw_ptr_update[i]),
            .sw_ptr       (sw_ptr[ch_lsb(i, PW) +: PW]),
            .coal_count   (coal_count),
            .coal_timeout (coal_timeout),
            .clr_fire     (clr[i]),
            .fire         (fire[i])
        );
    end

    // Request FSM with registered outputs and post-ack idle gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            send_q  <= 1'b0;
            vec_q   <= '0;
            gap_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (take) begin
                        state_q <= ST_REQ;
                        send_q  <= 1'b1;
                        vec_q   <= fire;
                    end
                end
                ST_REQ: begin
                    if (irq_ack) begin
                        state_q <= ST_HOLD;
                        send_q  <= 1'b0;
                        vec_q   <= '0;
                        gap_q   <= GW'(GAP);
                    end
                end
                ST_HOLD: begin
                    if (gap_q <= GW'(1))
                        state_q <= ST_IDLE;
                    else
                        gap_q <= gap_q - GW'(1);
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_irq_coal.sv
// tb_tx_irq_coal: directed scoreboard bench for tx_irq_coal.
// Expected irq_vec values are queued at stimulus time.
module tb_tx_irq_coal;

    localparam int NCH = 2;
    localparam int PW  = 64;
    localparam int TW  = 16;
    localparam int CW  = 8;
    localparam int GAP = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    data_rdy;
    logic [NCH-1:0]    data_rdy_ack;
    logic [NCH*PW-1:0] hw_ptr;
    logic [NCH-1:0]    sw_ptr_update;
    logic [NCH*PW-1:0] sw_ptr;
    logic              irq_en;
    logic [CW-1:0]     coal_count;
    logic [TW-1:0]     coal_timeout;
    logic              send_irq;
    logic              irq_ack;
    logic [NCH-1:0]    irq_vec;

    int total = 0;
    int bad   = 0;
    logic [NCH-1:0] exp_q[$];

    always #5 clk = ~clk;

    tx_irq_coal #(
        .NCH(NCH),
        .PW (PW),
        .TW (TW),
        .CW (CW),
        .GAP(GAP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_rdy     (data_rdy),
        .data_rdy_ack (data_rdy_ack),
        .hw_ptr       (hw_ptr),
        .sw_ptr_update(sw_ptr_update),
        .sw_ptr       (sw_ptr),
        .irq_en       (irq_en),
        .coal_count   (coal_count),
        .coal_timeout (coal_timeout),
        .send_irq     (send_irq),
        .irq_ack      (irq_ack),
        .irq_vec      (irq_vec)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic ev(input int ch, input logic [PW-1:0] p);
        data_rdy[ch] = 1'b1;
        hw_ptr[ch*PW +: PW] = p;
        step();
        chk("ack", 64'(data_rdy_ack), 64'(1) << ch);
        data_rdy[ch] = 1'b0;
    endtask

    task automatic sw_upd(input logic [NCH-1:0] m,
                          input logic [PW-1:0] p0,
                          input logic [PW-1:0] p1);
        sw_ptr_update = m;
        sw_ptr[0 +: PW]  = p0;
        sw_ptr[PW +: PW] = p1;
        step();
        sw_ptr_update = '0;
    endtask

    task automatic quiet(input string tag, input int n);
        repeat (n) begin
            step();
            chk(tag, 64'(send_irq), 64'd0);
        end
    endtask

    // Wait (bounded) for send_irq; check vector and edge latency.
    task automatic wait_irq(input string tag, input int lat);
        int n;
        logic [NCH-1:0] e;
        n = 0;
        while (!send_irq && n < 100) begin
            step();
            n++;
        end
        chk({tag, "_rise"}, 64'(send_irq), 64'd1);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_sb observed=irq expected=none", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_vec"}, 64'(irq_vec), 64'(e));
        end
        chk({tag, "_lat"}, 64'(n), 64'(lat));
    endtask

    task automatic do_ack(input string tag);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk({tag, "_drop"}, 64'(send_irq), 64'd0);
        chk({tag, "_vec0"}, 64'(irq_vec), 64'd0);
        repeat (GAP + 1) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=done");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        data_rdy = '0;
        hw_ptr = '0;
        sw_ptr_update = '0;
        sw_ptr = '0;
        irq_en = 1'b1;
        coal_count = CW'(1);
        coal_timeout = '0;
        irq_ack = 1'b0;
        repeat (3) step();
        chk("rst_send", 64'(send_irq), 64'd0);
        chk("rst_vec", 64'(irq_vec), 64'd0);
        chk("rst_ack", 64'(data_rdy_ack), 64'd0);
        rst = 1'b0;
        quiet("idle", 2);

        // single event, count threshold 1
        ev(0, 64'h10);
        exp_q.push_back(2'b01);
        wait_irq("t1", 1);
        chk("t1_ack_once", 64'(data_rdy_ack), 64'd0);
        // ch1 event during REQ waits for the gap to expire
        ev(1, 64'h20);
        chk("t1_hold_send", 64'(send_irq), 64'd1);
        chk("t1_hold_vec", 64'(irq_vec), 64'd1);
        exp_q.push_back(2'b10);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("t1_drop", 64'(send_irq), 64'd0);
        chk("t1_vec0", 64'(irq_vec), 64'd0);
        quiet("t1_gap", GAP);
        wait_irq("t1_after_gap", 1);
        do_ack("t1b");
        sw_upd(2'b11, 64'h10, 64'h20);
        quiet("t1_clean", 3);

        // count threshold 3
        coal_count = CW'(3);
        ev(1, 64'h1);
        quiet("t2_e1", 3);
        ev(1, 64'h2);
        quiet("t2_e2", 3);
        ev(1, 64'h3);
        exp_q.push_back(2'b10);
        wait_irq("t2", 1);
        do_ack("t2");
        sw_upd(2'b10, 64'h10, 64'h3);

        // timeout 20: request one edge after the timer hits 20
        coal_count = CW'(8);
        coal_timeout = TW'(20);
        ev(0, 64'h11);
        exp_q.push_back(2'b01);
        wait_irq("t3", 21);
        do_ack("t3");
        ev(0, 64'h12);
        quiet("t3_disarmed", 5);
        ev(0, 64'h18);
        quiet("t3_disarmed2", 25);

        // re-arm while still behind: timeout 5
        coal_timeout = TW'(5);
        sw_upd(2'b01, 64'h10, 64'h3);
        exp_q.push_back(2'b01);
        wait_irq("t4", 6);
        do_ack("t4");
        sw_upd(2'b01, 64'h18, 64'h3);
        quiet("t4_caught_up", 20);

        // both channels in one request
        coal_count = CW'(1);
        coal_timeout = '0;
        data_rdy = 2'b11;
        hw_ptr[0 +: PW]  = 64'h19;
        hw_ptr[PW +: PW] = 64'h4;
        step();
        chk("t5_ack", 64'(data_rdy_ack), 64'h3);
        data_rdy = '0;
        exp_q.push_back(2'b11);
        wait_irq("t5", 1);
        do_ack("t5");
        sw_upd(2'b11, 64'h19, 64'h4);

        // same-cycle capture and sw update leaves evt_cnt=1
        coal_count = CW'(2);
        ev(1, 64'h5);
        quiet("t5_cnt1", 3);
        data_rdy[1] = 1'b1;
        hw_ptr[PW +: PW] = 64'h6;
        sw_ptr_update = 2'b10;
        sw_ptr[PW +: PW] = 64'h4;
        step();
        chk("t5_same_ack", 64'(data_rdy_ack), 64'h2);
        data_rdy = '0;
        sw_ptr_update = '0;
        quiet("t5_same", 4);
        ev(1, 64'h7);
        exp_q.push_back(2'b10);
        wait_irq("t5_same", 1);
        do_ack("t5s");
        sw_upd(2'b10, 64'h19, 64'h7);

        // irq_en gating, then reset during REQ
        coal_count = CW'(1);
        irq_en = 1'b0;
        ev(0, 64'h1a);
        quiet("t6_dis", 5);
        irq_en = 1'b1;
        exp_q.push_back(2'b01);
        wait_irq("t6", 1);
        rst = 1'b1;
        step();
        chk("t6_rst_send", 64'(send_irq), 64'd0);
        chk("t6_rst_vec", 64'(irq_vec), 64'd0);
        rst = 1'b0;
        quiet("t6_after_rst", 3);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("t6_stray_ack", 64'(send_irq), 64'd0);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
